// File: rtl/ce_synth_pkg.sv
// ce_synth_pkg: shared types and helpers for the clock-enable synthesiser.
//   cfg_op_e  - configuration opcodes carried on cfg_op
//   CFG_OP_W  - width of the cfg_op field
//   inc_for() - rounded NCO increment for a wanted output rate, used when
//               building INC_INIT at instantiation time
package ce_synth_pkg;

  localparam int unsigned CFG_OP_W = 2;

  typedef enum logic [CFG_OP_W-1:0] {
    OP_SET_INC = 2'b00,
    OP_SET_EN  = 2'b01,
    OP_ALIGN   = 2'b10,
    OP_RSVD    = 2'b11
  } cfg_op_e;

  // inc = round(f_out * 2^acc_w / f_ref)
  function automatic longint unsigned inc_for(
    input longint unsigned f_out,
    input longint unsigned f_ref,
    input int unsigned     acc_w
  );
    longint unsigned scaled;
    scaled = f_out << acc_w;
    return (scaled + (f_ref >> 1)) / f_ref;
  endfunction

endpackage

// File: rtl/ce_synth_nco.sv
// ce_synth_nco: one phase-accumulator channel of ce_synth.
//   refclk   - reference clock
//   rst      - asynchronous active-low reset
//   load_inc - load inc_new into the increment register this edge
//   inc_new  - replacement increment
//   set_en   - load en_new into the enable register this edge
//   en_new   - replacement enable
//   align    - clear the accumulator and suppress ce this edge
//   ce       - registered carry of the accumulator (one-cycle pulse)
//   load_ok  - a new increment may be taken now without a short period:
//              the carry is happening this cycle, or the channel is idle
module ce_synth_nco
  import ce_synth_pkg::*;
#(
  parameter int unsigned      ACC_W   = 24,
  parameter logic [ACC_W-1:0] INC_RST = '0,
  parameter logic             EN_RST  = 1'b1
)(
  input  logic             refclk,
  input  logic             rst,
  input  logic             load_inc,
  input  logic [ACC_W-1:0] inc_new,
  input  logic             set_en,
  input  logic             en_new,
  input  logic             align,
  output logic             ce,
  output logic             load_ok
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic             en;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, inc};
    load_ok = (en & sum[ACC_W]) | ~en | (inc == '0);
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      inc <= INC_RST;
      en  <= EN_RST;
      ce  <= 1'b0;
    end else begin
      if (align) begin
        acc <= '0;
        ce  <= 1'b0;
      end else if (en) begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end else begin
        ce  <= 1'b0;
      end
      // The sum above still uses the old inc, so a load on the carry
      // edge finishes the current period at the old rate.
      if (load_inc) inc <= inc_new;
      if (set_en)   en  <= en_new;
    end
  end

endmodule

// File: rtl/ce_synth.sv
// ce_synth: NUM_CH clock-enable pulse trains from one reference clock.
//   refclk    - sole clock
//   rst       - asynchronous active-low reset
//   cfg_valid - configuration request
//   cfg_ready - single pending slot is free
//   cfg_op    - 00 set increment, 01 set enable, 10 phase-align all,
//               11 reserved (accepted, no effect)
//   cfg_ch    - target channel for ops 00/01 (out of range is ignored)
//   cfg_data  - increment (op 00) or enable in bit 0 (op 01)
//   ce        - one-cycle enable pulses, one bit per channel
//   locked    - rates stable: LOCK_CYCLES quiet cycles since last change
module ce_synth
  import ce_synth_pkg::*;
#(
  parameter int unsigned              NUM_CH      = 2,
  parameter int unsigned              ACC_W       = 24,
  parameter logic [NUM_CH*ACC_W-1:0]  INC_INIT    = '0,
  parameter logic [NUM_CH-1:0]        EN_INIT     = '1,
  parameter int unsigned              LOCK_CYCLES = 16,
  localparam int unsigned             CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_OP_W-1:0] cfg_op,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_data,
  output logic [NUM_CH-1:0]   ce,
  output logic                locked
);

  localparam int unsigned     CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic              pending;
  cfg_op_e           p_op;
  logic [CH_W-1:0]   p_ch;
  logic [ACC_W-1:0]  p_data;
  logic              accept;
  logic              apply_done;
  logic              align;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] load_ok;
  logic [NUM_CH-1:0] load_inc;
  logic [NUM_CH-1:0] set_en;
  logic [CNT_W-1:0]  lock_cnt;

  assign accept = cfg_valid & cfg_ready;

  // An out-of-range p_ch matches no channel, so the request simply retires.
  always_comb begin
    align = pending && (p_op == OP_ALIGN);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i]      = (p_ch == CH_W'(i));
      load_inc[i] = pending && (p_op == OP_SET_INC) && hit[i] && load_ok[i];
      set_en[i]   = pending && (p_op == OP_SET_EN) && hit[i];
    end
    apply_done = pending && ((p_op != OP_SET_INC) || !(|hit) || (|load_inc));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ce_synth_nco #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_INIT[g*ACC_W +: ACC_W]),
      .EN_RST  (EN_INIT[g])
    ) u_nco (
      .refclk   (refclk),
      .rst      (rst),
      .load_inc (load_inc[g]),
      .inc_new  (p_data),
      .set_en   (set_en[g]),
      .en_new   (p_data[0]),
      .align    (align),
      .ce       (ce[g]),
      .load_ok  (load_ok[g])
    );
  end

  // cfg_ready is registered as the complement of the next pending state,
  // so it is low throughout reset and rises on the first edge after it.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      pending   <= 1'b0;
      p_op      <= OP_SET_INC;
      p_ch      <= '0;
      p_data    <= '0;
      cfg_ready <= 1'b0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        p_op    <= cfg_op_e'(cfg_op);
        p_ch    <= cfg_ch;
        p_data  <= cfg_data;
      end else if (apply_done) begin
        pending <= 1'b0;
      end
      cfg_ready <= ~(accept | (pending & ~apply_done));
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (accept) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (pending) begin
      lock_cnt <= '0;
    end else if (!locked) begin
      if (lock_cnt == CNT_LAST) locked <= 1'b1;
      else                      lock_cnt <= lock_cnt + 1'b1;
    end
  end

endmodule

// File: doc/ce_synth.md
Name: ce_synth

Overview:
- Parametrised all-digital successor to the fixed two-output PLL wrapper.
- Generates NUM_CH independent clock-enable pulse trains from the single reference clock using per-channel phase accumulators (NCO), so cores get fractional rates such as 20/40 MHz from 50 MHz without extra PLLs.
- Adds what the PLL lacks: runtime rate reprogramming, per-channel enable, glitch-free rate changes and a global phase-align command.
- Sits beside the core's PLL and feeds the ce_* inputs of video and CPU blocks.

Parameters:
- NUM_CH, 2, number of enable channels (1..8).
- ACC_W, 24, accumulator and increment width. Channel rate = f_refclk * inc / 2^ACC_W.
- INC_INIT, {NUM_CH{ACC_W'(0)}}, packed reset increments; channel 0 occupies the LSBs.
- EN_INIT, all ones, reset per-channel enable mask.
- LOCK_CYCLES, 16, settle count before locked asserts (>=1).

Ports:
- refclk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config slot free.
- cfg_op  in  2  00 = set increment, 01 = set enable, 10 = phase align all, 11 = reserved (accepted, no effect).
- cfg_ch  in  clog2(NUM_CH) (min 1)  target channel for ops 00 and 01.
- cfg_data  in  ACC_W  increment (op 00) or enable in bit 0 (op 01).
- ce  out  NUM_CH  one-cycle enable pulses, one bit per channel.
- locked  out  1  rates stable.

Behaviour:
- Reset state while rst=0:
  - Accumulators = 0, inc = INC_INIT, en = EN_INIT.
  - ce = 0, locked = 0, cfg_ready = 0, pending cleared, lock counter = 0.
- After rst rises:
  - cfg_ready = 1 on the first edge.
  - The lock counter starts.
- Accumulator per channel, each cycle with en[i]=1:
  - sum = {1'b0, acc} + inc, ACC_W+1 bits.
  - acc <= sum[ACC_W-1:0].
  - ce[i] <= sum[ACC_W] (registered, so one-cycle latency from the carry).
  - With en[i]=0: acc holds and ce[i] = 0.
  - inc=0 gives no pulses. inc=2^(ACC_W-1) gives a pulse every 2nd cycle. ce is never high on two consecutive cycles unless inc >= 2^(ACC_W-1).
- Config handshake:
  - A request is accepted when cfg_valid & cfg_ready.
  - There is one pending slot, and cfg_ready = ~pending.
  - Request fields are held in the slot.
- Applying op 00 (glitch-free):
  - The new inc loads in the same cycle the target's carry occurs, so the completing period uses the old inc and the next period uses the new one.
  - The load is immediate, the cycle after acceptance, if the target has en=0 or current inc=0.
  - The pending slot then clears.
- Applying op 01:
  - Takes effect the cycle after acceptance.
  - Disabling leaves acc frozen. Re-enabling resumes from the frozen phase.
- Applying op 10:
  - The cycle after acceptance, all accumulators = 0 and ce = 0.
  - All enabled channels then restart in phase.
- Lock counter:
  - locked drops to 0 in the cycle following any accept.
  - The counter clears while pending=1.
  - Once pending=0, the counter counts LOCK_CYCLES cycles and then locked = 1. It holds until the next accept or reset.
- Simultaneous events:
  - A carry and the apply cycle coincide: the new inc is used for that cycle's next sum.
  - An accept and an apply cannot coincide, because the slot is single.
- Range checks:
  - cfg_ch >= NUM_CH: the request is accepted and ignored, but the locked drop still occurs.
  - A target inc=0 with en=1 and op 00 applies immediately.
- Reset mid-operation: pending is discarded and all state returns to reset values asynchronously.

Decomposition:
- Package ce_synth_pkg holds:
  - cfg_op enum: OP_SET_INC, OP_SET_EN, OP_ALIGN, OP_RSVD.
  - A helper function inc_for(f_out, f_ref, acc_w) returning the rounded increment for INC_INIT.
- Sub-module ce_synth_nco (one channel) covers the accumulator, en, inc register, load-on-carry and the align clear. It is instantiated NUM_CH times by generate.
- The top level holds the cfg slot and the lock counter.

Test Plan:
- Reset release, ACC_W=8, INC_INIT={64,128}:
  - ce[1] pulses every 2nd cycle and ce[0] every 4th.
  - locked rises exactly 16 cycles after release.
  - cfg_ready = 1 one cycle after release.
- 50→20 MHz with inc=102, 10000 cycles, ACC_W=8:
  - Pulse count is 3984 (floor(10000*102/256)).
  - Gaps are only ever 2 or 3 cycles.
- Set inc 64→128 on ch0 mid-period:
  - The current 4-cycle period completes.
  - Next gaps are 2.
  - cfg_ready stays low until the carry.
  - locked drops, then rises 16 cycles after the apply.
- Op 01 disable ch1, wait 7 cycles, re-enable:
  - No ce[1] while disabled.
  - The first pulse after re-enable is at the phase-consistent offset (frozen acc).
- Op 10 with ch0=64 and ch1=96 running:
  - Next cycle ce=0 and both acc=0.
  - The first common pulse from both channels occurs at cycle 8 after align.
- rst asserted while an op 00 is pending:
  - ce, locked and cfg_ready go to 0 immediately.
  - After release, inc = INC_INIT, not the pending value.
